latex_pair_streamer: RTL and testbench

LATEX_PAIR_STREAMER -- requirements
Module: latex_pair_streamer

---
 rtl/latex_pair_streamer.sv | 239 +++++++++++++++++++++++
 tb/tb_latex_pair_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latex_pair_streamer.sv
// Streams a pair of NUL-terminated strings (lhs/rhs) out of a packed 16-bit character memory,
// one byte pair per ready/valid beat, with bad-index and runaway-length error reporting.
module latex_pair_streamer #(
    parameter int LINE_W    = 6,
    parameter int NUM_LINES = 50,
    parameter int ADDR_W    = 10,
    parameter int MAX_BEATS = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LINE_W-1:0]   line,
    input  logic [1:0]          mode,
    output logic [LINE_W-1:0]   ptr_line,
    input  logic [2*ADDR_W-1:0] ptr_data,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [15:0]         mem_dout,
    output logic [7:0]          lhs,
    output logic [7:0]          rhs,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [7:0]          beat_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PTR     = 3'd1,
        FETCH_L = 3'd2,
        FETCH_R = 3'd3,
        CAPT    = 3'd4,
        EMIT_HI = 3'd5,
        EMIT_LO = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [LINE_W:0] LINE_LIMIT = (LINE_W + 1)'(NUM_LINES);
    localparam logic [7:0]      BEAT_LIMIT = 8'(MAX_BEATS);

    // Mode 3 is reserved and behaves like mode 2 (both sides active).
    function automatic logic side_active(input logic [1:0] m, input logic is_lhs);
        return is_lhs ? (m != 2'd1) : (m != 2'd0);
    endfunction

    function automatic logic [7:0] side_byte(input logic act, input logic ended,
                                             input logic [15:0] word, input logic hi);
        logic [7:0] b;
        b = hi ? word[15:8] : word[7:0];
        return (act && !ended) ? b : 8'h00;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [LINE_W-1:0]   line_r, line_nxt_s;
    logic [1:0]          mode_r, mode_nxt_s;
    logic [ADDR_W-1:0]   lhs_ptr_r, lhs_ptr_nxt_s, rhs_ptr_r, rhs_ptr_nxt_s;
    logic [15:0]         lhs_word_r, lhs_word_nxt_s, rhs_word_r, rhs_word_nxt_s;
    logic                lhs_end_r, lhs_end_nxt_s, rhs_end_r, rhs_end_nxt_s;
    logic                err_r, err_nxt_s;
    logic [7:0]          beat_count_r, beat_count_nxt_s, beat_inc_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
    logic [7:0]          lhs_r, lhs_nxt_s, rhs_r, rhs_nxt_s;
    logic                out_valid_r, out_valid_nxt_s, busy_r, done_r;
    logic                emit_s, hi_s, all_zero_s, lhs_hit_s, rhs_hit_s;
    logic [7:0]          cur_lhs_s, cur_rhs_s;
    logic                nxt_emit_s, nxt_hi_s;
    logic [7:0]          nxt_lhs_s, nxt_rhs_s;

    // What the current emit state presents, and which active side just hit its NUL.
    always_comb begin
        emit_s     = (state_r == EMIT_HI) || (state_r == EMIT_LO);
        hi_s       = (state_r == EMIT_HI);
        cur_lhs_s  = side_byte(emit_s && side_active(mode_r, 1'b1), lhs_end_r, lhs_word_r, hi_s);
        cur_rhs_s  = side_byte(emit_s && side_active(mode_r, 1'b0), rhs_end_r, rhs_word_r, hi_s);
        lhs_hit_s  = emit_s && side_active(mode_r, 1'b1) && !lhs_end_r &&
                     (side_byte(1'b1, 1'b0, lhs_word_r, hi_s) == 8'h00);
        rhs_hit_s  = emit_s && side_active(mode_r, 1'b0) && !rhs_end_r &&
                     (side_byte(1'b1, 1'b0, rhs_word_r, hi_s) == 8'h00);
        all_zero_s = (cur_lhs_s == 8'h00) && (cur_rhs_s == 8'h00);
        beat_inc_s = beat_count_r + 8'd1;
    end

    // Next-state and next datapath values.
    always_comb begin
        state_nxt_s      = state_r;
        line_nxt_s       = line_r;
        mode_nxt_s       = mode_r;
        lhs_ptr_nxt_s    = lhs_ptr_r;
        rhs_ptr_nxt_s    = rhs_ptr_r;
        lhs_word_nxt_s   = lhs_word_r;
        rhs_word_nxt_s   = rhs_word_r;
        lhs_end_nxt_s    = lhs_end_r;
        rhs_end_nxt_s    = rhs_end_r;
        err_nxt_s        = err_r;
        beat_count_nxt_s = beat_count_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    line_nxt_s       = line;
                    mode_nxt_s       = mode;
                    beat_count_nxt_s = 8'd0;
                    if ({1'b0, line} >= LINE_LIMIT) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        err_nxt_s   = 1'b0;
                        state_nxt_s = PTR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PTR: begin
                lhs_ptr_nxt_s = ptr_data[2*ADDR_W-1:ADDR_W];
                rhs_ptr_nxt_s = ptr_data[ADDR_W-1:0];
                lhs_end_nxt_s = 1'b0;
                rhs_end_nxt_s = 1'b0;
                state_nxt_s   = FETCH_L;
            end
            FETCH_L: state_nxt_s = FETCH_R;
            FETCH_R: begin
                lhs_word_nxt_s = mem_dout;
                state_nxt_s    = CAPT;
            end
            CAPT: begin
                rhs_word_nxt_s = mem_dout;
                state_nxt_s    = EMIT_HI;
            end
            EMIT_HI, EMIT_LO: begin
                lhs_end_nxt_s = lhs_end_r | lhs_hit_s;
                rhs_end_nxt_s = rhs_end_r | rhs_hit_s;
                if (all_zero_s) begin
                    state_nxt_s = DONE;
                end else if (out_ready) begin
                    beat_count_nxt_s = beat_inc_s;
                    if (beat_inc_s == BEAT_LIMIT) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = DONE;
                    end else if (state_r == EMIT_HI) begin
                        state_nxt_s = EMIT_LO;
                    end else begin
                        // Ended sides keep pointing at their NUL word; the refetch is ignored.
                        lhs_ptr_nxt_s = lhs_end_nxt_s ? lhs_ptr_r : lhs_ptr_r + ADDR_W'(1);
                        rhs_ptr_nxt_s = rhs_end_nxt_s ? rhs_ptr_r : rhs_ptr_r + ADDR_W'(1);
                        state_nxt_s   = FETCH_L;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the values the next state will hold.
    always_comb begin
        nxt_emit_s      = (state_nxt_s == EMIT_HI) || (state_nxt_s == EMIT_LO);
        nxt_hi_s        = (state_nxt_s == EMIT_HI);
        nxt_lhs_s       = side_byte(nxt_emit_s && side_active(mode_nxt_s, 1'b1),
                                    lhs_end_nxt_s, lhs_word_nxt_s, nxt_hi_s);
        nxt_rhs_s       = side_byte(nxt_emit_s && side_active(mode_nxt_s, 1'b0),
                                    rhs_end_nxt_s, rhs_word_nxt_s, nxt_hi_s);
        out_valid_nxt_s = nxt_emit_s && ((nxt_lhs_s != 8'h00) || (nxt_rhs_s != 8'h00));
        lhs_nxt_s       = nxt_lhs_s;
        rhs_nxt_s       = nxt_rhs_s;
        if (state_nxt_s == FETCH_L) begin
            mem_addr_nxt_s = lhs_ptr_nxt_s;
        end else if (state_nxt_s == FETCH_R) begin
            mem_addr_nxt_s = rhs_ptr_nxt_s;
        end else begin
            mem_addr_nxt_s = mem_addr_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Transfer context: latched request, pointers, words, end flags and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r       <= '0;
            mode_r       <= 2'd0;
            lhs_ptr_r    <= '0;
            rhs_ptr_r    <= '0;
            lhs_word_r   <= 16'h0000;
            rhs_word_r   <= 16'h0000;
            lhs_end_r    <= 1'b0;
            rhs_end_r    <= 1'b0;
            err_r        <= 1'b0;
            beat_count_r <= 8'd0;
        end else begin
            line_r       <= line_nxt_s;
            mode_r       <= mode_nxt_s;
            lhs_ptr_r    <= lhs_ptr_nxt_s;
            rhs_ptr_r    <= rhs_ptr_nxt_s;
            lhs_word_r   <= lhs_word_nxt_s;
            rhs_word_r   <= rhs_word_nxt_s;
            lhs_end_r    <= lhs_end_nxt_s;
            rhs_end_r    <= rhs_end_nxt_s;
            err_r        <= err_nxt_s;
            beat_count_r <= beat_count_nxt_s;
        end
    end

    // Registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_r  <= '0;
            lhs_r       <= 8'h00;
            rhs_r       <= 8'h00;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            mem_addr_r  <= mem_addr_nxt_s;
            lhs_r       <= lhs_nxt_s;
            rhs_r       <= rhs_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= (state_nxt_s == DONE);
        end
    end

    assign ptr_line   = line_r;
    assign mem_addr   = mem_addr_r;
    assign lhs        = lhs_r;
    assign rhs        = rhs_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign beat_count = beat_count_r;

endmodule

// File: tb/tb_latex_pair_streamer.sv
// Self-checking bench for latex_pair_streamer: pointer table and character memory models,
// expected beats queued per scenario and compared against the beats the sink accepts.
module tb_latex_pair_streamer;

    logic        clk, rst_n, start, out_ready;
    logic [5:0]  line, ptr_line;
    logic [1:0]  mode;
    logic [19:0] ptr_data;
    logic [9:0]  mem_addr;
    logic [15:0] mem_dout;
    logic [7:0]  lhs, rhs, beat_count;
    logic        out_valid, busy, done, err;

    logic [15:0] mem [0:1023];
    logic [7:0]  exp_l[$], exp_r[$], obs_l[$], obs_r[$];
    int          n_vec, n_miss;

    latex_pair_streamer #(.LINE_W(6), .NUM_LINES(50), .ADDR_W(10), .MAX_BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .line(line), .mode(mode),
        .ptr_line(ptr_line), .ptr_data(ptr_data), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .lhs(lhs), .rhs(rhs), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_dout <= mem[mem_addr];

    always_comb begin
        case (ptr_line)
            6'd3:    ptr_data = {10'h010, 10'h020};
            6'd5:    ptr_data = {10'h000, 10'h040};
            default: ptr_data = 20'h00000;
        endcase
    end

    task automatic push_exp(input logic [7:0] l, input logic [7:0] r);
        exp_l.push_back(l);
        exp_r.push_back(r);
    endtask

    // Request a transfer; line/mode are scrambled right after acceptance.
    task automatic kick(input logic [5:0] l, input logic [1:0] m);
        @(posedge clk); #1;
        start = 1'b1; line = l; mode = m;
        @(posedge clk); #1;
        start = 1'b0; line = 6'd50; mode = ~m;
    endtask

    // Record accepted beats until done or the cycle budget runs out.
    task automatic collect(input int budget, output bit got_done, output int n_cyc, output int first_v);
        got_done = 1'b0; n_cyc = 0; first_v = -1;
        obs_l.delete(); obs_r.delete();
        while (!got_done && n_cyc < budget) begin
            @(negedge clk);
            n_cyc++;
            if (out_valid && first_v < 0) first_v = n_cyc;
            if (out_valid && out_ready) begin
                obs_l.push_back(lhs);
                obs_r.push_back(rhs);
            end
            if (done) got_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({out_valid, done, busy, err, lhs, rhs, beat_count, mem_addr, ptr_line} !== 47'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got v=%b d=%b b=%b e=%b lhs=%h rhs=%h cnt=%0d addr=%h pl=%0d, required all 0",
                     out_valid, done, busy, err, lhs, rhs, beat_count, mem_addr, ptr_line);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_pair_both();
        bit gd; int nc, fv; logic [7:0] el, er, ol, orr;
        out_ready = 1'b1;
        push_exp(8'h31, 8'h31); push_exp(8'h00, 8'h2F); push_exp(8'h00, 8'h73);
        kick(6'd3, 2'd2);
        collect(60, gd, nc, fv);
        n_vec++;
        if (!gd) begin n_miss++; $display("FAIL both_done: no done within %0d cycles, required done", nc); end
        n_vec++;
        if (fv != 5) begin n_miss++; $display("FAIL both_latency: first valid at cycle %0d, required 5", fv); end
        while (exp_l.size() > 0) begin
            el = exp_l.pop_front(); er = exp_r.pop_front();
            n_vec++;
            if (obs_l.size() == 0) begin
                n_miss++; $display("FAIL both_beat: missing beat, required lhs=%h rhs=%h", el, er);
            end else begin
                ol = obs_l.pop_front(); orr = obs_r.pop_front();
                if (ol !== el || orr !== er) begin
                    n_miss++; $display("FAIL both_beat: got lhs=%h rhs=%h, required lhs=%h rhs=%h", ol, orr, el, er);
                end
            end
        end
        n_vec++;
        if (obs_l.size() != 0) begin n_miss++; $display("FAIL both_extra: %0d extra beats, required 0", obs_l.size()); end
        n_vec++;
        if (beat_count !== 8'd3 || err !== 1'b0) begin
            n_miss++; $display("FAIL both_status: got cnt=%0d err=%b, required cnt=3 err=0", beat_count, err);
        end
    endtask

    task automatic test_bad_line();
        bit gd; int nc, fv;
        out_ready = 1'b1;
        kick(6'd50, 2'd2);
        collect(10, gd, nc, fv);
        n_vec++;
        if (!gd || nc != 1) begin
            n_miss++; $display("FAIL badline_done: got done=%b at cycle %0d, required done at cycle 1", gd, nc);
        end
        n_vec++;
        if (fv != -1 || err !== 1'b1) begin
            n_miss++; $display("FAIL badline_err: got first_valid=%0d err=%b, required -1 and 1", fv, err);
        end
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_miss++; $display("FAIL badline_sticky: got err=%b busy=%b done=%b, required 1 0 0", err, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        bit gd; int nc, fv; logic [7:0] ol, orr;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; line = 6'd3; mode = 2'd0;
        @(posedge clk); #1;
        for (int t = 0; t < 2; t++) begin
            collect(60, gd, nc, fv);
            n_vec++;
            if (!gd || obs_l.size() != 1) begin
                n_miss++; $display("FAIL b2b_len[%0d]: got done=%b beats=%0d, required done and 1 beat", t, gd, obs_l.size());
            end else begin
                ol = obs_l.pop_front(); orr = obs_r.pop_front();
                if (ol !== 8'h31 || orr !== 8'h00) begin
                    n_miss++; $display("FAIL b2b_beat[%0d]: got lhs=%h rhs=%h, required 31 00", t, ol, orr);
                end
            end
            n_vec++;
            if (beat_count !== 8'd1 || err !== 1'b0) begin
                n_miss++; $display("FAIL b2b_status[%0d]: got cnt=%0d err=%b, required 1 0", t, beat_count, err);
            end
            if (t == 0) begin
                @(negedge clk);
                n_vec++;
                if (busy !== 1'b0) begin n_miss++; $display("FAIL b2b_gap: got busy=%b, required 0", busy); end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic test_stall_rhs();
        bit gd; int nc, fv, w; logic [7:0] el, er, ol, orr;
        out_ready = 1'b0;
        kick(6'd3, 2'd1);
        w = 0;
        do begin @(negedge clk); w++; end while (!out_valid && w < 20);
        n_vec++;
        if (!out_valid) begin n_miss++; $display("FAIL stall_wait: no out_valid in %0d cycles, required valid", w); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || lhs !== 8'h00 || rhs !== 8'h31 || beat_count !== 8'd0) begin
                n_miss++;
                $display("FAIL stall_hold[%0d]: got v=%b lhs=%h rhs=%h cnt=%0d, required 1 00 31 0",
                         k, out_valid, lhs, rhs, beat_count);
            end
        end
        out_ready = 1'b1;
        push_exp(8'h00, 8'h2F); push_exp(8'h00, 8'h73);
        collect(60, gd, nc, fv);
        while (exp_l.size() > 0) begin
            el = exp_l.pop_front(); er = exp_r.pop_front();
            n_vec++;
            if (obs_l.size() == 0) begin
                n_miss++; $display("FAIL stall_beat: missing beat, required lhs=%h rhs=%h", el, er);
            end else begin
                ol = obs_l.pop_front(); orr = obs_r.pop_front();
                if (ol !== el || orr !== er) begin
                    n_miss++; $display("FAIL stall_beat: got lhs=%h rhs=%h, required lhs=%h rhs=%h", ol, orr, el, er);
                end
            end
        end
        n_vec++;
        if (!gd || beat_count !== 8'd3) begin
            n_miss++; $display("FAIL stall_status: got done=%b cnt=%0d, required 1 3", gd, beat_count);
        end
    endtask

    task automatic test_runaway();
        bit gd; int nc, fv; logic [7:0] el, er, ol, orr;
        out_ready = 1'b1;
        push_exp(8'h00, 8'h41); push_exp(8'h00, 8'h42); push_exp(8'h00, 8'h43); push_exp(8'h00, 8'h44);
        kick(6'd5, 2'd1);
        collect(80, gd, nc, fv);
        while (exp_l.size() > 0) begin
            el = exp_l.pop_front(); er = exp_r.pop_front();
            n_vec++;
            if (obs_l.size() == 0) begin
                n_miss++; $display("FAIL runaway_beat: missing beat, required lhs=%h rhs=%h", el, er);
            end else begin
                ol = obs_l.pop_front(); orr = obs_r.pop_front();
                if (ol !== el || orr !== er) begin
                    n_miss++; $display("FAIL runaway_beat: got lhs=%h rhs=%h, required lhs=%h rhs=%h", ol, orr, el, er);
                end
            end
        end
        n_vec++;
        if (obs_l.size() != 0) begin n_miss++; $display("FAIL runaway_extra: %0d extra beats, required 0", obs_l.size()); end
        n_vec++;
        if (!gd || err !== 1'b1 || beat_count !== 8'd4) begin
            n_miss++; $display("FAIL runaway_status: got done=%b err=%b cnt=%0d, required 1 1 4", gd, err, beat_count);
        end
    endtask

    task automatic test_reset_mid();
        int w, dc;
        out_ready = 1'b0;
        kick(6'd3, 2'd2);
        w = 0;
        do begin @(negedge clk); w++; end while (!out_valid && w < 20);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || lhs !== 8'h00 || rhs !== 8'h2F) begin
            n_miss++; $display("FAIL rstmid_lo: got v=%b lhs=%h rhs=%h, required 1 00 2f", out_valid, lhs, rhs);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, done, busy, err, lhs, rhs, beat_count, mem_addr, ptr_line} !== 47'd0) begin
            n_miss++;
            $display("FAIL rstmid_outputs: got v=%b d=%b b=%b e=%b lhs=%h rhs=%h cnt=%0d addr=%h pl=%0d, required all 0",
                     out_valid, done, busy, err, lhs, rhs, beat_count, mem_addr, ptr_line);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (4) begin @(negedge clk); if (done || busy) dc++; end
        n_vec++;
        if (dc != 0) begin n_miss++; $display("FAIL rstmid_quiet: got %0d cycles with done/busy, required 0", dc); end
        test_pair_both();
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; start = 1'b0; line = 6'd0; mode = 2'd0; out_ready = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = 16'h0000;
        mem[10'h010] = 16'h3100;
        mem[10'h020] = 16'h312F;
        mem[10'h021] = 16'h7300;
        mem[10'h040] = 16'h4142;
        mem[10'h041] = 16'h4344;
        mem[10'h042] = 16'h4546;
        test_reset();
        test_pair_both();
        test_bad_line();
        test_back_to_back();
        test_stall_rhs();
        test_runaway();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
